// File: rtl/sample_bridge_pkg.sv
// Shared defaults and width helpers for the sample frame bridge and its capture FIFO.
package sample_bridge_pkg;

    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_SAMPLE_W   = 32;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_DIV_W      = 16;

    // Index width with a floor of one bit so single-channel builds still get a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int frame_w(input int channels, input int sample_w);
        return channels * sample_w;
    endfunction

endpackage

// File: rtl/sample_frame_fifo.sv
// Frame-wide synchronous FIFO with a registered head frame and occupancy level.
module sample_frame_fifo
    import sample_bridge_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = level_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_addr_r;
    logic [AW-1:0]    rd_addr_r;
    logic [AW-1:0]    rd_addr_nxt_s;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] head_r;
    logic             push_s;
    logic             pop_s;

    assign full          = (level_r == LW'(DEPTH));
    assign empty         = (level_r == {LW{1'b0}});
    assign push_s        = push && !full;
    assign pop_s         = pop && !empty;
    assign rd_addr_nxt_s = rd_addr_r + AW'(1);
    assign head          = head_r;
    assign level         = level_r;

    // Frame storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_addr_r] <= din;
        end
    end

    // Pointers, level, and the head frame that will be visible next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_r <= {AW{1'b0}};
            rd_addr_r <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            head_r    <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_addr_r <= wr_addr_r + AW'(1);
            end
            if (pop_s) begin
                rd_addr_r <= rd_addr_nxt_s;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            // An empty (or emptying) FIFO takes its new head straight from the input.
            if (push_s && (empty || (pop_s && (level_r == LW'(1))))) begin
                head_r <= din;
            end else if (pop_s && (level_r > LW'(1))) begin
                head_r <= mem_r[rd_addr_nxt_s];
            end
        end
    end

endmodule

// File: rtl/sample_frame_bridge.sv
// Sample-rate bridge: strobe divider, frame capture FIFO with word serialiser,
// and a staged output frame presented atomically on each strobe.
module sample_frame_bridge
    import sample_bridge_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIV_W      = DEF_DIV_W,
    localparam int CW = idx_w(CHANNELS),
    localparam int LW = level_w(FIFO_DEPTH),
    localparam int FW = frame_w(CHANNELS, SAMPLE_W)
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    div_value,
    input  logic [FW-1:0]       sample_in,
    output logic                sample_clk,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic [CW-1:0]       rd_chan,
    output logic                rd_valid,
    input  logic                rd_ready,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [FW-1:0]       sample_out,
    output logic [LW-1:0]       fill_level,
    output logic                overrun,
    output logic                underrun,
    input  logic                clear_flags
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic             tick_s;
    logic             sample_clk_r;
    logic [CW-1:0]    rd_chan_r;
    logic             rd_xfer_s;
    logic             rd_last_s;
    logic             pop_s;
    logic [CW-1:0]    wr_chan_r;
    logic             wr_xfer_s;
    logic             wr_last_s;
    logic             frame_ready_r;
    logic [FW-1:0]    staging_r;
    logic [FW-1:0]    sample_out_r;
    logic             overrun_r;
    logic             underrun_r;
    logic [FW-1:0]    fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LW-1:0]    fifo_level_s;

    sample_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (tick_s),
        .pop   (pop_s),
        .din   (sample_in),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    assign rd_xfer_s = !fifo_empty_s && rd_ready;
    assign rd_last_s = (rd_chan_r == CW'(CHANNELS - 1));
    assign pop_s     = rd_xfer_s && rd_last_s;
    assign wr_xfer_s = wr_valid && !frame_ready_r;
    assign wr_last_s = (wr_chan_r == CW'(CHANNELS - 1));

    assign sample_clk = sample_clk_r;
    assign rd_data    = fifo_head_s[int'(rd_chan_r) * SAMPLE_W +: SAMPLE_W];
    assign rd_chan    = rd_chan_r;
    assign rd_valid   = !fifo_empty_s;
    assign wr_ready   = !frame_ready_r;
    assign sample_out = sample_out_r;
    assign fill_level = fifo_level_s;
    assign overrun    = overrun_r;
    assign underrun   = underrun_r;

    // Divider: tick once the count reaches div_value; lowering div_value ticks at once.
    always_comb begin
        tick_s    = 1'b0;
        cnt_nxt_s = {DIV_W{1'b0}};
        if (!enable) begin
            tick_s    = 1'b0;
            cnt_nxt_s = {DIV_W{1'b0}};
        end else if (cnt_r >= div_value) begin
            tick_s    = 1'b1;
            cnt_nxt_s = {DIV_W{1'b0}};
        end else begin
            tick_s    = 1'b0;
            cnt_nxt_s = cnt_r + DIV_W'(1);
        end
    end

    // Divider count and the registered strobe.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cnt_r        <= {DIV_W{1'b0}};
            sample_clk_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            sample_clk_r <= tick_s;
        end
    end

    // Read serialiser channel index; the last channel retires the head frame.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rd_chan_r <= {CW{1'b0}};
        end else if (rd_xfer_s) begin
            rd_chan_r <= rd_last_s ? {CW{1'b0}} : rd_chan_r + CW'(1);
        end
    end

    // Output staging; a frame completed in a strobe cycle waits for the next strobe.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_chan_r     <= {CW{1'b0}};
            frame_ready_r <= 1'b0;
            staging_r     <= {FW{1'b0}};
            sample_out_r  <= {FW{1'b0}};
        end else begin
            if (wr_xfer_s) begin
                staging_r[int'(wr_chan_r) * SAMPLE_W +: SAMPLE_W] <= wr_data;
                wr_chan_r <= wr_last_s ? {CW{1'b0}} : wr_chan_r + CW'(1);
            end
            if (tick_s && frame_ready_r) begin
                sample_out_r  <= staging_r;
                frame_ready_r <= 1'b0;
            end else if (wr_xfer_s && wr_last_s) begin
                frame_ready_r <= 1'b1;
            end
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (tick_s && fifo_full_s) begin
                overrun_r <= 1'b1;
            end else if (clear_flags) begin
                overrun_r <= 1'b0;
            end
            if (tick_s && !frame_ready_r) begin
                underrun_r <= 1'b1;
            end else if (clear_flags) begin
                underrun_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_bridge.sv
// Self-checking bench: queue-based behavioural model compared every cycle,
// directed literal checks for the key scenarios, then randomized traffic.
module tb_sample_frame_bridge;

    localparam int CH = 2;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int FW = CH * W;

    logic          clk_clk     = 1'b0;
    logic          reset_reset = 1'b0;
    logic          enable      = 1'b0;
    logic [DW-1:0] div_value   = '0;
    logic [FW-1:0] sample_in   = '0;
    logic          rd_ready    = 1'b0;
    logic [W-1:0]  wr_data     = '0;
    logic          wr_valid    = 1'b0;
    logic          clear_flags = 1'b0;

    logic          sample_clk;
    logic [W-1:0]  rd_data;
    logic [0:0]    rd_chan;
    logic          rd_valid;
    logic          wr_ready;
    logic [FW-1:0] sample_out;
    logic [4:0]    fill_level;
    logic          overrun;
    logic          underrun;

    sample_frame_bridge #(
        .CHANNELS   (CH),
        .SAMPLE_W   (W),
        .FIFO_DEPTH (D),
        .DIV_W      (DW)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .enable      (enable),
        .div_value   (div_value),
        .sample_in   (sample_in),
        .sample_clk  (sample_clk),
        .rd_data     (rd_data),
        .rd_chan     (rd_chan),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .sample_out  (sample_out),
        .fill_level  (fill_level),
        .overrun     (overrun),
        .underrun    (underrun),
        .clear_flags (clear_flags)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] frame(input int k);
        return {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
    endfunction

    // Behavioural model: integer divider, frame queue, word-array staging.
    int            m_cnt    = 0;
    bit            m_sclk   = 1'b0;
    logic [FW-1:0] m_q[$];
    int            m_rdchan = 0;
    bit            m_ovr    = 1'b0;
    bit            m_und    = 1'b0;
    logic [W-1:0]  m_stage[CH];
    int            m_wrchan = 0;
    bit            m_fready = 1'b0;
    logic [FW-1:0] m_sout   = '0;

    always @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            m_cnt = 0; m_sclk = 1'b0; m_q.delete(); m_rdchan = 0;
            m_ovr = 1'b0; m_und = 1'b0; m_wrchan = 0; m_fready = 1'b0; m_sout = '0;
            for (int k = 0; k < CH; k++) m_stage[k] = '0;
        end else begin
            bit tick;
            bit full_pre;
            bit fready_pre;
            bit pop;
            tick       = enable && (m_cnt >= int'(div_value));
            m_cnt      = (!enable || tick) ? 0 : m_cnt + 1;
            full_pre   = (m_q.size() == D);
            fready_pre = m_fready;
            pop        = 1'b0;
            if (m_q.size() != 0 && rd_ready) begin
                if (m_rdchan == CH - 1) begin
                    pop = 1'b1;
                    m_rdchan = 0;
                end else begin
                    m_rdchan++;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (tick && !full_pre) m_q.push_back(sample_in);
            if (tick && fready_pre) begin
                for (int k = 0; k < CH; k++) m_sout[k*W +: W] = m_stage[k];
                m_fready = 1'b0;
            end
            if (wr_valid && !fready_pre) begin
                m_stage[m_wrchan] = wr_data;
                if (m_wrchan == CH - 1) begin
                    m_wrchan = 0;
                    m_fready = 1'b1;
                end else begin
                    m_wrchan++;
                end
            end
            if (tick && full_pre) m_ovr = 1'b1;
            else if (clear_flags) m_ovr = 1'b0;
            if (tick && !fready_pre) m_und = 1'b1;
            else if (clear_flags) m_und = 1'b0;
            m_sclk = tick;
        end
    end

    // Single compare process: every output against the model, every cycle.
    logic [FW-1:0] c_head;
    always @(negedge clk_clk) begin
        if (model_on) begin
            chk("sample_clk", 64'(sample_clk), 64'(m_sclk));
            chk("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                c_head = m_q[0];
                chk("rd_data", 64'(rd_data), 64'(c_head[m_rdchan*W +: W]));
                chk("rd_chan", 64'(rd_chan), 64'(m_rdchan));
            end
            chk("wr_ready", 64'(wr_ready), 64'(!m_fready));
            chk("sample_out", sample_out, m_sout);
            chk("fill_level", 64'(fill_level), 64'(m_q.size()));
            chk("overrun", 64'(overrun), 64'(m_ovr));
            chk("underrun", 64'(underrun), 64'(m_und));
        end
    end

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset_reset = 1'b1;
        enable = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0; clear_flags = 1'b0;
        step();
        reset_reset = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_clk);
            if (sample_clk) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk(name, 64'(0), 64'(1));
    endtask

    task automatic write_word(input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk_clk);
        wr_valid = 1'b0;
    endtask

    int n;
    int rd_pct;

    initial begin
        #3 reset_reset = 1'b1;
        step();
        step();
        reset_reset = 1'b0;
        model_on = 1'b1;

        // Reset values.
        @(negedge clk_clk);
        chk("rst_sample_clk", 64'(sample_clk), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(1));
        chk("rst_sample_out", sample_out, 64'(0));
        chk("rst_fill_level", 64'(fill_level), 64'(0));

        // Strobe timing and single-frame serialisation.
        step();
        sample_in = {32'hBBBB0002, 32'hAAAA0001};
        rd_ready  = 1'b1;
        div_value = 16'd3;
        enable    = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_clk);
            n++;
            if (sample_clk) break;
        end
        chk("first_strobe_delay", 64'(n), 64'(5));
        chk("cap_rd_valid", 64'(rd_valid), 64'(1));
        chk("cap_word0", 64'(rd_data), 64'(32'hAAAA0001));
        chk("cap_chan0", 64'(rd_chan), 64'(0));
        chk("cap_fill1", 64'(fill_level), 64'(1));
        @(negedge clk_clk);
        chk("cap_word1", 64'(rd_data), 64'(32'hBBBB0002));
        chk("cap_chan1", 64'(rd_chan), 64'(1));
        @(negedge clk_clk);
        chk("cap_fill0", 64'(fill_level), 64'(0));
        n = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_clk);
            n++;
            if (sample_clk) break;
        end
        chk("strobe_period", 64'(n), 64'(4));

        // Fill to overrun, clear, then drain in order.
        do_reset();
        div_value = 16'd3;
        sample_in = frame(1);
        enable    = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            wait_strobe("ovr_strobe_timeout");
            sample_in = frame(k + 1);
            if (k == 16) begin
                chk("ovr_fill_at16", 64'(fill_level), 64'(16));
                chk("ovr_flag_at16", 64'(overrun), 64'(0));
            end
        end
        chk("ovr_fill_at17", 64'(fill_level), 64'(16));
        chk("ovr_flag_at17", 64'(overrun), 64'(1));
        enable = 1'b0;
        clear_flags = 1'b1;
        @(negedge clk_clk);
        clear_flags = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'(0));
        rd_ready = 1'b1;
        for (int f = 1; f <= 16; f++) begin
            for (int c = 0; c < CH; c++) begin
                chk("drain_valid", 64'(rd_valid), 64'(1));
                chk("drain_word", 64'(rd_data), (c == 0) ? 64'(32'hA000_0000 + 32'(f))
                                                          : 64'(32'hB000_0000 + 32'(f)));
                @(negedge clk_clk);
            end
        end
        chk("drain_empty", 64'(fill_level), 64'(0));

        // Complete output frame presented on the strobe.
        do_reset();
        @(negedge clk_clk);
        write_word(32'h11);
        write_word(32'h22);
        chk("wr_ready_held", 64'(wr_ready), 64'(0));
        div_value = 16'd3;
        enable = 1'b1;
        wait_strobe("present_timeout");
        chk("present_frame", sample_out, {32'h22, 32'h11});
        chk("present_wr_ready", 64'(wr_ready), 64'(1));

        // Incomplete frame at the strobe gives underrun; completed frame follows.
        write_word(32'h33);
        wait_strobe("underrun_timeout");
        chk("underrun_set", 64'(underrun), 64'(1));
        chk("underrun_hold", sample_out, {32'h22, 32'h11});
        clear_flags = 1'b1;
        write_word(32'h44);
        clear_flags = 1'b0;
        chk("underrun_cleared", 64'(underrun), 64'(0));
        wait_strobe("late_present_timeout");
        chk("late_present", sample_out, {32'h44, 32'h33});

        // Asynchronous reset while the serialiser is on channel 1.
        do_reset();
        @(negedge clk_clk);
        write_word(32'h55);
        write_word(32'h66);
        sample_in = frame(7);
        rd_ready  = 1'b1;
        div_value = 16'd3;
        enable    = 1'b1;
        wait_strobe("areset_timeout");
        @(negedge clk_clk);
        chk("areset_pre_chan", 64'(rd_chan), 64'(1));
        chk("areset_pre_out", sample_out, {32'h66, 32'h55});
        #2 reset_reset = 1'b1;
        #1;
        chk("areset_rd_valid", 64'(rd_valid), 64'(0));
        chk("areset_rd_chan", 64'(rd_chan), 64'(0));
        chk("areset_rd_data", 64'(rd_data), 64'(0));
        chk("areset_sample_out", sample_out, 64'(0));
        chk("areset_fill", 64'(fill_level), 64'(0));
        chk("areset_wr_ready", 64'(wr_ready), 64'(1));
        chk("areset_sample_clk", 64'(sample_clk), 64'(0));
        step();
        reset_reset = 1'b0;

        // Randomized traffic with varying consumer pressure.
        for (int blk = 0; blk < 6; blk++) begin
            rd_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 95);
            div_value = DW'($urandom_range(0, 3));
            for (int i = 0; i < 500; i++) begin
                step();
                enable = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 49) == 0) div_value = DW'($urandom_range(0, 6));
                rd_ready    = ($urandom_range(0, 99) < rd_pct);
                wr_valid    = ($urandom_range(0, 2) != 0);
                wr_data     = $urandom();
                sample_in   = {$urandom(), $urandom()};
                clear_flags = ($urandom_range(0, 39) == 0);
            end
            do_reset();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
